// File: rtl/usb_tx_bitstuff_nrzi_pkg.sv
// Shared encodings for the USB transmit bit-stuff / NRZI stage.
// Line levels and default run lengths live here.
package usb_tx_bitstuff_nrzi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_STUFF,
    ST_HOLD,
    ST_EOP0,
    ST_EOP1,
    ST_EOPJ
  } tx_state_e;

  localparam logic J_LEVEL       = 1'b1;
  localparam int   STUFF_LEN_DEF = 6;
  localparam int   EOP_GAP_DEF   = 4;

endpackage

// File: rtl/usb_tx_bitstuff_nrzi_bit_fifo.sv
// One-bit-wide synchronous FIFO; a write into a full FIFO
// is accepted when a read happens in the same cycle.
module bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic wr_bit,
  input  logic rd_en,
  output logic rd_bit,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [AW:0]   C_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_rd, do_wr;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == C_FULL);
  assign rd_bit = mem_q[rp_q];
  assign do_rd  = rd_en & ~empty;
  assign do_wr  = wr_en & (~full | do_rd);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_wr) begin
      mem_d[wp_q] = wr_bit;
      wp_d        = wp_q + P_ONE;
    end
    if (do_rd) begin
      rp_d = rp_q + P_ONE;
    end
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + C_ONE;
    end else if (!do_wr && do_rd) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_bitstuff_nrzi.sv
// USB transmit stage: bit stuffing, NRZI encoding and EOP framing
// behind a bit FIFO that soaks up the stuffed-bit rate mismatch.
module usb_tx_bitstuff_nrzi
  import usb_tx_bitstuff_nrzi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int EOP_GAP    = EOP_GAP_DEF,
  parameter int STUFF_LEN  = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ser_in,
  input  logic ser_in_val,
  output logic nrzi_out,
  output logic nrzi_out_val,
  output logic eop_out,
  output logic busy,
  output logic overflow
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int GW = $clog2(EOP_GAP + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [OW-1:0] ONES_ONE = OW'(1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(EOP_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  tx_state_e     state_q, state_d;
  logic [OW-1:0] ones_q, ones_d, ones_inc;
  logic [GW-1:0] gap_q, gap_d;
  logic          lvl_q, lvl_d;
  logic          nrzi_q, nrzi_d;
  logic          val_q, val_d;
  logic          eop_q, eop_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          pop, rd_bit, fifo_full, fifo_empty;

  bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (ser_in_val),
    .wr_bit (ser_in),
    .rd_en  (pop),
    .rd_bit (rd_bit),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign ones_inc = ones_q + ONES_ONE;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    gap_d   = gap_q;
    lvl_d   = lvl_q;
    val_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SEND, ST_HOLD: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          val_d   = 1'b1;
          gap_d   = '0;
          state_d = ST_SEND;
          if (rd_bit) begin
            ones_d = ones_inc;
            if (ones_inc == ONES_MAX) begin
              state_d = ST_STUFF;
            end
          end else begin
            ones_d = '0;
            lvl_d  = ~lvl_q;
          end
        end else if (state_q != ST_IDLE) begin
          // Ones run survives the gap; only EOP entry forgets it
          state_d = ST_HOLD;
          if (ser_in_val) begin
            gap_d = '0;
          end else if (gap_q == GAP_MAX) begin
            state_d = ST_EOP0;
            gap_d   = '0;
            ones_d  = '0;
          end else begin
            gap_d = gap_q + GAP_ONE;
          end
        end
      end
      ST_STUFF: begin
        val_d   = 1'b1;
        lvl_d   = ~lvl_q;
        ones_d  = '0;
        state_d = fifo_empty ? ST_HOLD : ST_SEND;
      end
      ST_EOP0: begin
        gap_d   = '0;
        state_d = ST_EOP1;
      end
      ST_EOP1: begin
        gap_d   = '0;
        lvl_d   = J_LEVEL;
        state_d = ST_EOPJ;
      end
      ST_EOPJ: begin
        gap_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    eop_d  = (state_d == ST_EOP0) || (state_d == ST_EOP1);
    nrzi_d = eop_d ? 1'b0 : lvl_d;
    busy_d = (state_d != ST_IDLE);
    ovf_d  = ovf_q | (ser_in_val & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ones_q  <= '0;
      gap_q   <= '0;
      lvl_q   <= J_LEVEL;
      nrzi_q  <= J_LEVEL;
      val_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      gap_q   <= gap_d;
      lvl_q   <= lvl_d;
      nrzi_q  <= nrzi_d;
      val_q   <= val_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign nrzi_out     = nrzi_q;
  assign nrzi_out_val = val_q;
  assign eop_out      = eop_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_usb_tx_bitstuff_nrzi.sv
// Directed bench for usb_tx_bitstuff_nrzi: per-cycle traces
// compared against hand-derived line sequences.
module tb_usb_tx_bitstuff_nrzi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_in = 1'b0;
  logic ser_in_val = 1'b0;
  logic a_n, a_v, a_e, a_b, a_o;
  logic b_n, b_v, b_e, b_b, b_o;

  int errs = 0;
  int checks = 0;

  logic tr_n [64];
  logic tr_v [64];
  logic tr_e [64];
  logic tr_b [64];
  logic tr_o1 [64];
  logic tr_o2 [64];

  usb_tx_bitstuff_nrzi dut (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .ser_in_val   (ser_in_val),
    .nrzi_out     (a_n),
    .nrzi_out_val (a_v),
    .eop_out      (a_e),
    .busy         (a_b),
    .overflow     (a_o)
  );

  usb_tx_bitstuff_nrzi #(
    .FIFO_DEPTH (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .ser_in_val   (ser_in_val),
    .nrzi_out     (b_n),
    .nrzi_out_val (b_v),
    .eop_out      (b_e),
    .busy         (b_b),
    .overflow     (b_o)
  );

  always #5 clk = ~clk;

  task automatic run_seq(input logic [63:0] bits,
                         input logic [63:0] vals,
                         input int n);
    for (int c = 0; c < n; c++) begin
      ser_in     = bits[c];
      ser_in_val = vals[c];
      @(posedge clk);
      #1;
      tr_n[c]  = a_n;
      tr_v[c]  = a_v;
      tr_e[c]  = a_e;
      tr_b[c]  = a_b;
      tr_o1[c] = a_o;
      tr_o2[c] = b_o;
    end
    ser_in     = 1'b0;
    ser_in_val = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ser_in_val = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) rst = 1'b0;
      @(posedge clk);
      #1;
      checks += 5;
      if ({a_n, a_v, a_e, a_b, a_o} !== 5'b10000) begin
        errs++;
        $display("FAIL reset c%0d n/v/e/b/o got %b want 10000",
                 c, {a_n, a_v, a_e, a_b, a_o});
      end
      if (b_o !== 1'b0) begin
        errs++;
        $display("FAIL reset dut2 overflow got %b want 0", b_o);
      end
    end
  endtask

  task automatic test_zeros();
    string en, ev, ee, eb;
    en = "101010101111100111";
    ev = "011111111000000000";
    ee = "000000000000011000";
    eb = "011111111111111100";
    run_seq(64'h0, 64'hFF, 18);
    for (int c = 0; c < 18; c++) begin
      checks += 4;
      if (tr_n[c] !== (en[c] == "1")) begin
        errs++;
        $display("FAIL zeros nrzi c%0d got %b want %c", c, tr_n[c], en[c]);
      end
      if (tr_v[c] !== (ev[c] == "1")) begin
        errs++;
        $display("FAIL zeros val c%0d got %b want %c", c, tr_v[c], ev[c]);
      end
      if (tr_e[c] !== (ee[c] == "1")) begin
        errs++;
        $display("FAIL zeros eop c%0d got %b want %c", c, tr_e[c], ee[c]);
      end
      if (tr_b[c] !== (eb[c] == "1")) begin
        errs++;
        $display("FAIL zeros busy c%0d got %b want %c", c, tr_b[c], eb[c]);
      end
    end
  endtask

  task automatic test_ones();
    string en, ev, ee, eb;
    en = "1111111000000000111";
    ev = "0111111111000000000";
    ee = "0000000000000011000";
    eb = "0111111111111111100";
    run_seq(64'hFF, 64'hFF, 19);
    for (int c = 0; c < 19; c++) begin
      checks += 4;
      if (tr_n[c] !== (en[c] == "1")) begin
        errs++;
        $display("FAIL ones nrzi c%0d got %b want %c", c, tr_n[c], en[c]);
      end
      if (tr_v[c] !== (ev[c] == "1")) begin
        errs++;
        $display("FAIL ones val c%0d got %b want %c", c, tr_v[c], ev[c]);
      end
      if (tr_e[c] !== (ee[c] == "1")) begin
        errs++;
        $display("FAIL ones eop c%0d got %b want %c", c, tr_e[c], ee[c]);
      end
      if (tr_b[c] !== (eb[c] == "1")) begin
        errs++;
        $display("FAIL ones busy c%0d got %b want %c", c, tr_b[c], eb[c]);
      end
    end
  endtask

  task automatic test_stuff_end();
    string en, ev, ee, eb;
    en = "11111110000000111";
    ev = "01111111000000000";
    ee = "00000000000011000";
    eb = "01111111111111100";
    run_seq(64'h3F, 64'h3F, 17);
    for (int c = 0; c < 17; c++) begin
      checks += 4;
      if (tr_n[c] !== (en[c] == "1")) begin
        errs++;
        $display("FAIL stuffend nrzi c%0d got %b want %c", c, tr_n[c], en[c]);
      end
      if (tr_v[c] !== (ev[c] == "1")) begin
        errs++;
        $display("FAIL stuffend val c%0d got %b want %c", c, tr_v[c], ev[c]);
      end
      if (tr_e[c] !== (ee[c] == "1")) begin
        errs++;
        $display("FAIL stuffend eop c%0d got %b want %c", c, tr_e[c], ee[c]);
      end
      if (tr_b[c] !== (eb[c] == "1")) begin
        errs++;
        $display("FAIL stuffend busy c%0d got %b want %c", c, tr_b[c], eb[c]);
      end
    end
  endtask

  task automatic test_gap();
    string en, ev, ee, eb;
    logic [63:0] bits, vals;
    en = "10101111111111010101000000011";
    ev = "01111111100011111111100000000";
    ee = "00000000000000000000000001100";
    eb = "01111111111111111111111111110";
    bits = 64'hF0 | (64'h03 << 11);
    vals = 64'hFF | (64'hFF << 11);
    run_seq(bits, vals, 29);
    for (int c = 0; c < 29; c++) begin
      checks += 4;
      if (tr_n[c] !== (en[c] == "1")) begin
        errs++;
        $display("FAIL gap nrzi c%0d got %b want %c", c, tr_n[c], en[c]);
      end
      if (tr_v[c] !== (ev[c] == "1")) begin
        errs++;
        $display("FAIL gap val c%0d got %b want %c", c, tr_v[c], ev[c]);
      end
      if (tr_e[c] !== (ee[c] == "1")) begin
        errs++;
        $display("FAIL gap eop c%0d got %b want %c", c, tr_e[c], ee[c]);
      end
      if (tr_b[c] !== (eb[c] == "1")) begin
        errs++;
        $display("FAIL gap busy c%0d got %b want %c", c, tr_b[c], eb[c]);
      end
    end
  endtask

  task automatic test_abort();
    run_seq(64'h0, 64'hFF, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({a_n, a_v, a_e, a_b, a_o} !== 5'b10000) begin
      errs++;
      $display("FAIL abort n/v/e/b/o got %b want 10000",
               {a_n, a_v, a_e, a_b, a_o});
    end
    run_seq(64'h0, 64'h0, 12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({tr_n[c], tr_v[c], tr_e[c], tr_b[c]} !== 4'b1000) begin
        errs++;
        $display("FAIL abort_idle c%0d n/v/e/b got %b want 1000",
                 c, {tr_n[c], tr_v[c], tr_e[c], tr_b[c]});
      end
    end
  endtask

  task automatic test_overflow();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq(64'h3FFF_FFFF, 64'h3FFF_FFFF, 30);
    for (int c = 0; c < 30; c++) begin
      checks += 2;
      if (tr_o2[c] !== (c >= 14)) begin
        errs++;
        $display("FAIL ovf2 c%0d got %b want %b", c, tr_o2[c], c >= 14);
      end
      if (tr_o1[c] !== 1'b0) begin
        errs++;
        $display("FAIL ovf8 c%0d got %b want 0", c, tr_o1[c]);
      end
    end
    run_seq(64'h0, 64'h0, 40);
    checks += 3;
    if (b_o !== 1'b1) begin
      errs++;
      $display("FAIL ovf2_sticky got %b want 1", b_o);
    end
    if (a_b !== 1'b0) begin
      errs++;
      $display("FAIL ovf8_drain busy got %b want 0", a_b);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (b_o !== 1'b0) begin
      errs++;
      $display("FAIL ovf2_clear got %b want 0", b_o);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_stuff_end();
    test_gap();
    test_abort();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_bitstuff_nrzi.md
Name: usb_tx_bitstuff_nrzi

Overview:
- Transmit-path stage directly downstream of the byte serializer. Consumes the LSB-first serial bit stream and its valid strobe.
- Applies USB bit stuffing: a 0 is inserted after six consecutive 1s. NRZI-encodes the result and frames each packet with an EOP.
- A small bit FIFO absorbs the rate mismatch caused by stuffed bits, since the serializer cannot be stalled.

Parameters:
- FIFO_DEPTH, 8: bit-FIFO depth (power of 2, ≥2).
- EOP_GAP, 4: consecutive cycles with FIFO empty and ser_in_val low that end a packet.
- STUFF_LEN, 6: run of 1s that triggers a stuffed 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ser_in  in  1  serial data bit, LSB-first order preserved
- ser_in_val  in  1  ser_in valid this cycle
- nrzi_out  out  1  NRZI line level (1 = J/idle)
- nrzi_out_val  out  1  nrzi_out carries a packet bit (data or stuffed)
- eop_out  out  1  SE0 phase of EOP
- busy  out  1  packet in progress (any state except IDLE)
- overflow  out  1  sticky; a bit was dropped

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - Reset values: nrzi_out=1, nrzi_out_val=0, eop_out=0, busy=0, overflow=0.
  - Also cleared: FIFO, ones counter, gap counter; state=IDLE.
  - Reset mid-packet aborts immediately. No EOP is emitted.
- FIFO write: on ser_in_val at the clock edge.
  - Full with no read in the same cycle: bit dropped, overflow←1.
  - Full with a read in the same cycle: write accepted.
- All outputs are registered. A bit sampled at edge k with the FIFO empty drives nrzi_out after edge k+1.
- NRZI rules: a data 0 toggles the line level, a data 1 holds it. A stuffed bit is a 0, so it toggles.
- Ones counter (0..STUFF_LEN):
  - Increments on each transmitted 1.
  - Clears on a transmitted 0, a stuffed bit, or entry to EOP.
- FSM:
  - IDLE: nrzi_out=1. FIFO non-empty → SEND.
  - SEND: each cycle with the FIFO non-empty:
    - pop one bit, drive its NRZI level, nrzi_out_val=1.
    - If the ones count reaches STUFF_LEN with this bit → STUFF.
    - FIFO empty → HOLD.
  - STUFF: one cycle. Toggle the line, nrzi_out_val=1, no pop. Then go to SEND if the FIFO is non-empty, else HOLD. Stuffing still occurs when the sixth 1 is the final packet bit.
  - HOLD: line level held, nrzi_out_val=0.
    - Gap counter increments while the FIFO is empty and ser_in_val=0.
    - Gap counter resets whenever ser_in_val=1.
    - FIFO non-empty → SEND, and the ones counter is preserved across the gap.
    - Gap counter reaching EOP_GAP → EOP0.
  - EOP0, EOP1: eop_out=1, nrzi_out=0, nrzi_out_val=0.
  - EOPJ: one cycle of nrzi_out=1, eop_out=0, then IDLE. Line level reference resets to J.
- Input arriving during the EOP states is written to the FIFO and sent as the next packet after IDLE. The gap counter is cleared.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SEND, STUFF, HOLD, EOP0, EOP1, EOPJ);
  - J_LEVEL=1;
  - default STUFF_LEN and EOP_GAP.
- One sub-module: bit_fifo. It is a 1-bit-wide synchronous FIFO with full/empty flags, parameterised FIFO_DEPTH, with read/write-same-cycle-when-full support. The parent instantiates it and holds the FSM, ones counter, gap counter and NRZI register.

Test Plan:
- Reset idle: hold rst 3 cycles, then idle → nrzi_out=1, nrzi_out_val=eop_out=busy=overflow=0 throughout.
- Byte 0x00 (8 zeros, contiguous valid):
  - nrzi_out sequence 0,1,0,1,0,1,0,1 with nrzi_out_val=1 for 8 cycles.
  - Then 4 gap cycles with the level held at 1.
  - Then eop_out=1 for 2 cycles with nrzi_out=0, then 1 cycle of J, busy=0.
- Byte 0xFF:
  - 6 cycles at 1, stuffed cycle at 0, 2 cycles at 0: 9 valid cycles total.
  - Then EOP. Ones count at EOP entry is 2.
- Stuff at packet end: bits 1,1,1,1,1,1 then idle → 6 held 1s, stuffed 0, HOLD, then EOP. The stuffed bit appears before SE0.
- Ones run across a byte gap:
  - 0xF0 (bits 0000 1111), 3 idle cycles, then 0x03 (bits 11 000000).
  - Stuffed 0 is inserted after the second bit of byte 2.
  - No EOP during the 3-cycle gap.
- Overflow: FIFO_DEPTH=2, 30 consecutive valid 1s → overflow rises and stays 1 until rst; a subsequent rst clears it to 0.
